pkg_in_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single 512-bit `io_data_in` stream of `PkgProc` among NUM_SRC upstream packet sources. It locks onto one source from first beat to `last`, rotates priority after each packet, and drives `PkgProc` through a 2-entry output buffer so back-pressure never breaks a packet or stalls throughput. It sits directly in front of `PkgProc` in the upload path.

---
 rtl/pkg_in_arbiter.sv | 168 ++++++++++++++++
 tb/tb_pkg_in_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkg_in_arbiter.sv
// Packet-granular round-robin arbiter feeding PkgProc through a 2-entry output buffer.
// Optional per-source packet counters are built when PKG_ARB_STATS_EN is defined.
module pkg_in_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 512,
    localparam int unsigned KEEP_W = DATA_W / 8,
    localparam int unsigned SRC_W  = $clog2(NUM_SRC)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_SRC-1:0]          io_src_valid,
    output logic [NUM_SRC-1:0]          io_src_ready,
    input  logic [NUM_SRC*DATA_W-1:0]   io_src_bits_data,
    input  logic [NUM_SRC*KEEP_W-1:0]   io_src_bits_keep,
    input  logic [NUM_SRC-1:0]          io_src_bits_last,
    output logic                        io_out_valid,
    input  logic                        io_out_ready,
    output logic [DATA_W-1:0]           io_out_bits_data,
    output logic [KEEP_W-1:0]           io_out_bits_keep,
    output logic                        io_out_bits_last,
    output logic [SRC_W-1:0]            io_out_src,
    output logic [31:0]                 io_idle_cycle,
    input  logic [SRC_W-1:0]            io_stat_sel,
    output logic [31:0]                 io_stat_pkts
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t             state;
    logic [SRC_W-1:0]   g;
    logic [SRC_W-1:0]   rr_ptr;

    logic [DATA_W-1:0]  mem_data [2];
    logic [KEEP_W-1:0]  mem_keep [2];
    logic               mem_last [2];
    logic [SRC_W-1:0]   mem_src  [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         buf_cnt;

    logic               win_found;
    logic [SRC_W-1:0]   winner;
    logic [SRC_W-1:0]   sel;
    logic               accept;
    logic               acc_last;
    logic               push;
    logic               pop;

    function automatic logic [SRC_W-1:0] inc_src(input logic [SRC_W-1:0] x);
        return (x == SRC_W'(NUM_SRC - 1)) ? '0 : x + 1'b1;
    endfunction

    // First valid source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            int unsigned idx;
            idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (!win_found && io_src_valid[idx]) begin
                win_found = 1'b1;
                winner    = SRC_W'(idx);
            end
        end
    end

    // Ready depends only on the registered buffer count, never on this cycle's pop.
    always_comb begin
        io_src_ready = '0;
        if (reset && buf_cnt < 2'd2) begin
            if (state == LOCK) begin
                io_src_ready[g] = 1'b1;
            end else if (win_found) begin
                io_src_ready[winner] = 1'b1;
            end
        end
    end

    assign sel          = (state == LOCK) ? g : winner;
    assign accept       = |(io_src_valid & io_src_ready);
    assign acc_last     = io_src_bits_last[sel];
    assign push         = accept;
    assign io_out_valid = (buf_cnt != 2'd0);
    assign pop          = io_out_valid & io_out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            g      <= '0;
            rr_ptr <= '0;
        end else if (accept) begin
            if (acc_last) begin
                state  <= IDLE;
                rr_ptr <= inc_src(sel);
            end else begin
                state <= LOCK;
                g     <= sel;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_keep[i] <= '0;
                mem_last[i] <= 1'b0;
                mem_src[i]  <= '0;
            end
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            buf_cnt <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= io_src_bits_data[sel*DATA_W +: DATA_W];
                mem_keep[wr_ptr] <= io_src_bits_keep[sel*KEEP_W +: KEEP_W];
                mem_last[wr_ptr] <= acc_last;
                mem_src[wr_ptr]  <= sel;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    assign io_out_bits_data = mem_data[rd_ptr];
    assign io_out_bits_keep = mem_keep[rd_ptr];
    assign io_out_bits_last = mem_last[rd_ptr];
    assign io_out_src       = mem_src[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_idle_cycle <= '0;
        end else if (!io_out_valid && io_idle_cycle != '1) begin
            io_idle_cycle <= io_idle_cycle + 32'd1;
        end
    end

`ifdef PKG_ARB_STATS_EN
    logic [31:0] pkt_cnt [NUM_SRC];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                pkt_cnt[i] <= '0;
            end
        end else if (accept && acc_last) begin
            pkt_cnt[sel] <= pkt_cnt[sel] + 32'd1;
        end
    end

    assign io_stat_pkts = (int'(io_stat_sel) < NUM_SRC) ? pkt_cnt[io_stat_sel] : '0;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^io_stat_sel;
    assign io_stat_pkts    = '0;
`endif

endmodule

// File: tb/tb_pkg_in_arbiter.sv
// Directed, table-driven bench for pkg_in_arbiter (4 sources, 512-bit beats).
module tb_pkg_in_arbiter;

    localparam int NS = 4;
    localparam int DW = 512;
    localparam int KW = DW / 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [NS-1:0]     io_src_valid;
    logic [NS-1:0]     io_src_ready;
    logic [NS*DW-1:0]  io_src_bits_data;
    logic [NS*KW-1:0]  io_src_bits_keep;
    logic [NS-1:0]     io_src_bits_last;
    logic              io_out_valid;
    logic              io_out_ready;
    logic [DW-1:0]     io_out_bits_data;
    logic [KW-1:0]     io_out_bits_keep;
    logic              io_out_bits_last;
    logic [1:0]        io_out_src;
    logic [31:0]       io_idle_cycle;
    logic [1:0]        io_stat_sel;
    logic [31:0]       io_stat_pkts;

    int checks = 0;
    int errors = 0;

    pkg_in_arbiter #(.NUM_SRC(NS), .DATA_W(DW)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_src_valid     (io_src_valid),
        .io_src_ready     (io_src_ready),
        .io_src_bits_data (io_src_bits_data),
        .io_src_bits_keep (io_src_bits_keep),
        .io_src_bits_last (io_src_bits_last),
        .io_out_valid     (io_out_valid),
        .io_out_ready     (io_out_ready),
        .io_out_bits_data (io_out_bits_data),
        .io_out_bits_keep (io_out_bits_keep),
        .io_out_bits_last (io_out_bits_last),
        .io_out_src       (io_out_src),
        .io_idle_cycle    (io_idle_cycle),
        .io_stat_sel      (io_stat_sel),
        .io_stat_pkts     (io_stat_pkts)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] src;
        logic       olast;
        int         tag;
    } vec_t;

    vec_t vecs [25];

    function automatic logic [DW-1:0] mk_data(input int s, input int t);
        logic [DW-1:0] d;
        d          = '0;
        d[15:0]    = 16'hA500 | 16'(s);
        d[47:16]   = 32'(t);
        d[511:480] = 32'hC0DE_0000 + 32'(s * 256 + t);
        return d;
    endfunction

    function automatic logic [KW-1:0] mk_keep(input int s);
        logic [KW-1:0] k;
        k = '1;
        return k >> (s * 4);
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] valid, input logic [3:0] last, input logic ordy, input int tag);
        io_src_valid     = valid;
        io_src_bits_last = last;
        io_out_ready     = ordy;
        for (int i = 0; i < NS; i++) begin
            io_src_bits_data[i*DW +: DW] = mk_data(i, tag);
            io_src_bits_keep[i*KW +: KW] = mk_keep(i);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Round robin, 3-beat lock, back-pressure, and mid-packet valid drop.
        vecs[0]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 0};
        vecs[1]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 1'b1, 0};
        vecs[2]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 1'b1, 1};
        vecs[3]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 1'b1, 2};
        vecs[4]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 1'b1, 3};
        vecs[5]  = '{4'h3, 4'h1, 1'b1, 4'h2, 1'b1, 2'd0, 1'b1, 4};
        vecs[6]  = '{4'h3, 4'h1, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 5};
        vecs[7]  = '{4'h3, 4'h3, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 6};
        vecs[8]  = '{4'h1, 4'h1, 1'b1, 4'h1, 1'b1, 2'd1, 1'b1, 7};
        vecs[9]  = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 1'b1, 8};
        vecs[10] = '{4'h4, 4'h4, 1'b0, 4'h4, 1'b0, 2'd0, 1'b0, 0};
        vecs[11] = '{4'h4, 4'h4, 1'b0, 4'h4, 1'b1, 2'd2, 1'b1, 10};
        vecs[12] = '{4'h4, 4'h4, 1'b0, 4'h0, 1'b1, 2'd2, 1'b1, 10};
        vecs[13] = '{4'h4, 4'h4, 1'b0, 4'h0, 1'b1, 2'd2, 1'b1, 10};
        vecs[14] = '{4'h4, 4'h4, 1'b0, 4'h0, 1'b1, 2'd2, 1'b1, 10};
        vecs[15] = '{4'h4, 4'h4, 1'b1, 4'h0, 1'b1, 2'd2, 1'b1, 10};
        vecs[16] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd2, 1'b1, 11};
        vecs[17] = '{4'h4, 4'h0, 1'b1, 4'h4, 1'b0, 2'd0, 1'b0, 0};
        vecs[18] = '{4'h8, 4'h8, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0, 17};
        vecs[19] = '{4'h8, 4'h8, 1'b1, 4'h4, 1'b0, 2'd0, 1'b0, 0};
        vecs[20] = '{4'h8, 4'h8, 1'b1, 4'h4, 1'b0, 2'd0, 1'b0, 0};
        vecs[21] = '{4'hC, 4'hC, 1'b1, 4'h4, 1'b0, 2'd0, 1'b0, 0};
        vecs[22] = '{4'h8, 4'h8, 1'b1, 4'h8, 1'b1, 2'd2, 1'b1, 21};
        vecs[23] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd3, 1'b1, 22};
        vecs[24] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 0};

        reset       = 1'b0;
        io_stat_sel = 2'd0;
        drive(4'hF, 4'hF, 1'b1, 99);
        next_cycle();
        next_cycle();
        chk("rst_ready", io_src_ready, 0);
        chk("rst_out_valid", io_out_valid, 0);
        chk("rst_out_data", io_out_bits_data, 0);
        chk("rst_out_keep", io_out_bits_keep, 0);
        chk("rst_out_last", io_out_bits_last, 0);
        chk("rst_out_src", io_out_src, 0);
        chk("rst_idle", io_idle_cycle, 0);
        chk("rst_stat", io_stat_pkts, 0);
        reset = 1'b1;

        for (int v = 0; v < 25; v++) begin
            drive(vecs[v].valid, vecs[v].last, vecs[v].ordy, v);
            #1;
            chk($sformatf("v%0d_ready", v), io_src_ready, vecs[v].rdy);
            chk($sformatf("v%0d_out_valid", v), io_out_valid, vecs[v].ov);
            if (vecs[v].ov) begin
                chk($sformatf("v%0d_out_src", v), io_out_src, vecs[v].src);
                chk($sformatf("v%0d_out_last", v), io_out_bits_last, vecs[v].olast);
                chk($sformatf("v%0d_out_data", v), io_out_bits_data, mk_data(vecs[v].src, vecs[v].tag));
                chk($sformatf("v%0d_out_keep", v), io_out_bits_keep, mk_keep(vecs[v].src));
            end
            next_cycle();
        end

        // Reset asserted while source 1 holds the lock with a beat buffered.
        drive(4'h2, 4'h0, 1'b0, 50);
        #1;
        chk("mid_lock_ready", io_src_ready, 4'h2);
        next_cycle();
        chk("mid_buffered", io_out_valid, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", io_out_valid, 0);
        chk("mid_rst_ready", io_src_ready, 0);
        chk("mid_rst_data", io_out_bits_data, 0);
        chk("mid_rst_src", io_out_src, 0);
        chk("mid_rst_last", io_out_bits_last, 0);
        chk("mid_rst_idle", io_idle_cycle, 0);
        next_cycle();
        reset = 1'b1;
        drive(4'hF, 4'hF, 1'b1, 60);
        #1;
        chk("restart_ready", io_src_ready, 4'h1);
        chk("restart_idle", io_idle_cycle, 0);
        next_cycle();
        chk("restart_out_valid", io_out_valid, 1);
        chk("restart_out_src", io_out_src, 0);
        chk("restart_out_data", io_out_bits_data, mk_data(0, 60));
        chk("restart_idle1", io_idle_cycle, 1);
        chk("restart_ready2", io_src_ready, 4'h2);
        next_cycle();
        chk("restart_out_src2", io_out_src, 1);
        chk("restart_out_last2", io_out_bits_last, 1);
        chk("restart_idle_hold", io_idle_cycle, 1);
        drive(4'h0, 4'h0, 1'b1, 0);
        next_cycle();
        next_cycle();
        chk("drain_idle", io_idle_cycle, 2);

        // Packet statistics: four packets from source 3, two from source 0.
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            drive(4'h8, 4'h8, 1'b1, n);
            next_cycle();
        end
        for (int n = 0; n < 2; n++) begin
            drive(4'h1, 4'h1, 1'b1, n);
            next_cycle();
        end
        drive(4'h0, 4'h0, 1'b1, 0);
        next_cycle();
        io_stat_sel = 2'd3;
        #1;
`ifdef PKG_ARB_STATS_EN
        chk("stat_src3", io_stat_pkts, 4);
`else
        chk("stat_src3", io_stat_pkts, 0);
`endif
        io_stat_sel = 2'd0;
        #1;
`ifdef PKG_ARB_STATS_EN
        chk("stat_src0", io_stat_pkts, 2);
`else
        chk("stat_src0", io_stat_pkts, 0);
`endif
        io_stat_sel = 2'd1;
        #1;
        chk("stat_src1", io_stat_pkts, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
